// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// reset PC default and the ROM-latency counter helper.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2
    } fetchState_t;

    localparam int RESET_PC_DEFAULT = 0;

    // Wide enough for ROM latencies 1..3 (counter starts at latency-1).
    localparam int CNT_W = 2;

    function automatic logic [CNT_W-1:0] latInit(input int romLat);
        return CNT_W'(romLat - 1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter register: load has priority over increment, increment wraps
// from all-ones to zero and flags the wrap combinationally.
module instr_fetch_unit_pc_counter
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadVal,
    output logic [ADDR_W-1:0] pc,
    output logic              wrap
);

    // A load on the same edge suppresses the increment, so it cannot wrap.
    assign wrap = inc && !load && (pc == '1);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= loadVal;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, ROM read sequencing and instruction register.
// Optional sticky error output fetchErr is enabled by defining FETCH_ERR_EN.
//
// state  | meaning
// S_IDLE | no fetch in flight, accepts iROMREAD
// S_WAIT | ROM read in progress, counting down ROM latency
// S_CAPT | ROM data valid, latch into IR
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                ROM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              iROMREAD,
    input  logic              pcINC,
    input  logic              pcLOAD,
    input  logic [ADDR_W-1:0] pcLoadVal,
    output logic [ADDR_W-1:0] romAddr,
    output logic              romEN,
    input  logic [DATA_W-1:0] romData,
    output logic [DATA_W-1:0] INS,
    output logic              insValid,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
`ifdef FETCH_ERR_EN
    ,
    output logic              fetchErr
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = latInit(ROM_LAT);

    fetchState_t       state, stateNxt;
    logic [CNT_W-1:0]  cnt, cntNxt;
    logic [ADDR_W-1:0] romAddrNxt;
    logic [DATA_W-1:0] irNxt;
    logic              insValidNxt;
    logic              pcWrap;

    instr_fetch_unit_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) pcCounter (
        .Clk     (Clk),
        .Rst     (Rst),
        .inc     (pcINC),
        .load    (pcLOAD),
        .loadVal (pcLoadVal),
        .pc      (pc),
        .wrap    (pcWrap)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // romAddr is captured once at request time so PC moves during WAIT are invisible to the ROM.
    always_comb begin
        stateNxt    = state;
        cntNxt      = cnt;
        romAddrNxt  = romAddr;
        irNxt       = INS;
        insValidNxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (iROMREAD) begin
                    stateNxt   = S_WAIT;
                    romAddrNxt = pc;
                    cntNxt     = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    stateNxt = S_CAPT;
                end else begin
                    cntNxt = cnt - CNT_W'(1);
                end
            end
            S_CAPT: begin
                irNxt       = romData;
                insValidNxt = 1'b1;
                stateNxt    = S_IDLE;
            end
            default: begin
                stateNxt = S_IDLE;
                cntNxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt      <= '0;
            romAddr  <= '0;
            INS      <= '0;
            insValid <= 1'b0;
        end else begin
            cnt      <= cntNxt;
            romAddr  <= romAddrNxt;
            INS      <= irNxt;
            insValid <= insValidNxt;
        end
    end

    assign romEN = (state == S_WAIT);
    assign busy  = (state != S_IDLE);

`ifdef FETCH_ERR_EN
    // A request overlapping the CAPT edge is a legal back-to-back attempt, only WAIT overlap is an error.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetchErr <= 1'b0;
        end else if ((state == S_WAIT && iROMREAD) || pcWrap) begin
            fetchErr <= 1'b1;
        end
    end
`else
    logic pcWrapUnused;
    assign pcWrapUnused = pcWrap;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (ROM latency 1 and 3) share stimulus,
// each checked every cycle against a transaction-level model plus literal checks.
module tb_instr_fetch_unit;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       iROMREAD, pcINC, pcLOAD;
    logic [7:0] pcLoadVal;

    logic [7:0] romAddr1, romAddr3, romData1, romData3, ins1, ins3, pc1, pc3;
    logic       romEN1, romEN3, valid1, valid3, busy1, busy3;
`ifdef FETCH_ERR_EN
    logic       err1, err3;
`endif

    logic [7:0] rom [256];
    logic [7:0] p1 = 8'h00;
    logic [7:0] p3 [3] = '{8'h00, 8'h00, 8'h00};

    int total = 0;
    int bad   = 0;
    bit chkEn = 0;

    always #5 Clk = ~Clk;

    instr_fetch_unit #(.ROM_LAT(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .iROMREAD(iROMREAD), .pcINC(pcINC), .pcLOAD(pcLOAD),
        .pcLoadVal(pcLoadVal), .romAddr(romAddr1), .romEN(romEN1), .romData(romData1),
        .INS(ins1), .insValid(valid1), .busy(busy1), .pc(pc1)
`ifdef FETCH_ERR_EN
        , .fetchErr(err1)
`endif
    );

    instr_fetch_unit #(.ROM_LAT(3)) dut3 (
        .Clk(Clk), .Rst(Rst), .iROMREAD(iROMREAD), .pcINC(pcINC), .pcLOAD(pcLOAD),
        .pcLoadVal(pcLoadVal), .romAddr(romAddr3), .romEN(romEN3), .romData(romData3),
        .INS(ins3), .insValid(valid3), .busy(busy3), .pc(pc3)
`ifdef FETCH_ERR_EN
        , .fetchErr(err3)
`endif
    );

    // ROMs with true pipeline latency: data sampled while enabled appears LAT edges later.
    always @(posedge Clk) begin
        p1    <= romEN1 ? rom[romAddr1] : 8'h00;
        p3[0] <= romEN3 ? rom[romAddr3] : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign romData1 = p1;
    assign romData3 = p3[2];

    // Reference model: a fetch accepted at edge s completes at s+LAT+1; the unit is
    // free again from edge s+LAT+2. Edges s+1..s+LAT are the waiting period.
    int         mEdge = 0;
    int         mStart [2] = '{-100, -100};
    logic [7:0] mAddr  [2] = '{8'h00, 8'h00};
    logic [7:0] mIns   [2] = '{8'h00, 8'h00};
    logic       mValid [2] = '{1'b0, 1'b0};
    logic       mErr   [2] = '{1'b0, 1'b0};
    logic [7:0] mPc = 8'h00;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mEdge = 0;
            mPc   = 8'h00;
            for (int i = 0; i < 2; i++) begin
                mStart[i] = -100;
                mAddr[i]  = 8'h00;
                mIns[i]   = 8'h00;
                mValid[i] = 1'b0;
                mErr[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mValid[i] = 1'b0;
                if (mEdge == mStart[i] + lat(i) + 1) begin
                    mIns[i]   = rom[mAddr[i]];
                    mValid[i] = 1'b1;
                end
                if (iROMREAD && mEdge > mStart[i] && mEdge <= mStart[i] + lat(i))
                    mErr[i] = 1'b1;
                if (iROMREAD && mEdge > mStart[i] + lat(i) + 1) begin
                    mStart[i] = mEdge;
                    mAddr[i]  = mPc;
                end
            end
            if (pcLOAD) begin
                mPc = pcLoadVal;
            end else if (pcINC) begin
                if (mPc == 8'hFF) begin
                    mErr[0] = 1'b1;
                    mErr[1] = 1'b1;
                end
                mPc = mPc + 8'd1;
            end
            mEdge++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmpInst(input int i, input string tag, input logic [7:0] ra, input logic en,
                           input logic bz, input logic [7:0] ins, input logic iv);
        int e;
        e = mEdge - 1;
        chk({tag, ".romAddr"},  ra, mAddr[i]);
        chk({tag, ".romEN"},    en, (e >= mStart[i] && e < mStart[i] + lat(i)));
        chk({tag, ".busy"},     bz, (e >= mStart[i] && e <= mStart[i] + lat(i)));
        chk({tag, ".INS"},      ins, mIns[i]);
        chk({tag, ".insValid"}, iv, mValid[i]);
    endtask

    always @(negedge Clk) begin
        if (chkEn && !Rst) begin
            chk("d1.pc", pc1, mPc);
            chk("d3.pc", pc3, mPc);
            cmpInst(0, "d1", romAddr1, romEN1, busy1, ins1, valid1);
            cmpInst(1, "d3", romAddr3, romEN3, busy3, ins3, valid3);
`ifdef FETCH_ERR_EN
            chk("d1.fetchErr", err1, mErr[0]);
            chk("d3.fetchErr", err3, mErr[1]);
`endif
        end
    end

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic rstPulse();
        #2 Rst = 1'b1;
        #1 Rst = 1'b0;
    endtask

    initial begin
        int c1, c3;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        rom[8'h00] = 8'h20;
        rom[8'h10] = 8'hC0;
        rom[8'h05] = 8'h55;
        Rst = 1'b1; iROMREAD = 1'b0; pcINC = 1'b0; pcLOAD = 1'b0; pcLoadVal = 8'h00;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        chkEn = 1;

        // Reset with a fetch in flight: outputs return to reset values immediately.
        pcLOAD = 1'b1; pcLoadVal = 8'h33; iROMREAD = 1'b1;
        tick();
        pcLOAD = 1'b0; iROMREAD = 1'b0;
        tick();
        #2 Rst = 1'b1;
        #1;
        chk("rst.pc1", pc1, 8'h00);
        chk("rst.pc3", pc3, 8'h00);
        chk("rst.ins3", ins3, 8'h00);
        chk("rst.busy3", busy3, 1'b0);
        chk("rst.romEN3", romEN3, 1'b0);
        chk("rst.romAddr1", romAddr1, 8'h00);
        chk("rst.valid1", valid1, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        tick();
        chk("rel.pc1", pc1, 8'h00);
        chk("rel.ins1", ins1, 8'h00);
        chk("rel.valid1", valid1, 1'b0);

        // Single fetch from PC 0.
        iROMREAD = 1'b1;
        tick();
        iROMREAD = 1'b0;
        chk("f0.romAddr1", romAddr1, 8'h00);
        chk("f0.romEN1", romEN1, 1'b1);
        tick();
        tick();
        chk("f0.ins1", ins1, 8'h20);
        chk("f0.valid1", valid1, 1'b1);
        chk("f0.busy1", busy1, 1'b0);
        tick();
        chk("f0.valid1off", valid1, 1'b0);
        tick();
        chk("f0.ins3", ins3, 8'h20);
        chk("f0.valid3", valid3, 1'b1);

        // Load beats increment, then fetch the jump target.
        pcLOAD = 1'b1; pcLoadVal = 8'h10; pcINC = 1'b1;
        tick();
        pcLOAD = 1'b0; pcINC = 1'b0;
        chk("ld.pc1", pc1, 8'h10);
        iROMREAD = 1'b1;
        tick();
        iROMREAD = 1'b0;
        repeat (4) tick();
        chk("ld.ins1", ins1, 8'hC0);
        chk("ld.ins3", ins3, 8'hC0);

        // PC increment during WAIT does not disturb the in-flight address.
        pcLOAD = 1'b1; pcLoadVal = 8'h05;
        tick();
        pcLOAD = 1'b0; iROMREAD = 1'b1;
        tick();
        iROMREAD = 1'b0; pcINC = 1'b1;
        tick();
        pcINC = 1'b0;
        repeat (3) tick();
        chk("inc.romAddr3", romAddr3, 8'h05);
        chk("inc.ins3", ins3, 8'h55);
        chk("inc.pc3", pc3, 8'h06);

        // Wrap from all-ones.
        pcLOAD = 1'b1; pcLoadVal = 8'hFF;
        tick();
        pcLOAD = 1'b0; pcINC = 1'b1;
        tick();
        pcINC = 1'b0;
        chk("wrap.pc1", pc1, 8'h00);
`ifdef FETCH_ERR_EN
        chk("wrap.err1", err1, 1'b1);
        repeat (3) tick();
        chk("wrap.err3sticky", err3, 1'b1);
`endif
        rstPulse();
        tick();
`ifdef FETCH_ERR_EN
        chk("wrap.errclr", err1, 1'b0);
`endif

        // Request overlapping only the CAPT edge of the latency-1 unit is dropped silently.
        iROMREAD = 1'b1;
        tick();
        iROMREAD = 1'b0;
        tick();
        iROMREAD = 1'b1;
        tick();
        iROMREAD = 1'b0;
        chk("capt.valid1", valid1, 1'b1);
        tick();
        chk("capt.busy1", busy1, 1'b0);
        chk("capt.romEN1", romEN1, 1'b0);
`ifdef FETCH_ERR_EN
        chk("capt.err1", err1, 1'b0);
`endif
        repeat (2) tick();

        // Held request: back-to-back fetches every LAT+2 edges.
        c1 = 0; c3 = 0;
        iROMREAD = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (valid1) c1++;
            if (valid3) c3++;
        end
        iROMREAD = 1'b0;
        chk("hold.count1", c1, 5);
        chk("hold.count3", c3, 3);
        repeat (6) tick();

        // Randomized traffic, occasional asynchronous reset pulses.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) rstPulse();
            iROMREAD  = ($urandom_range(0, 9) < 4);
            pcINC     = ($urandom_range(0, 9) < 3);
            pcLOAD    = ($urandom_range(0, 9) < 1);
            pcLoadVal = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            tick();
        end
        iROMREAD = 1'b0; pcINC = 1'b0; pcLOAD = 1'b0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
